// File: rtl/lcr580_pkg.sv
// Shared definitions for the LCR580 interrupt controller: FSM encoding and port map.
package lcr580_pkg;

  localparam int unsigned IRQ_IDX_W      = 3;
  localparam logic [7:0]  IRQ_PORT_BASE  = 8'hF0;
  localparam logic [7:0]  IRQ_EOI_OFFSET = 8'h01;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_WAIT = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit finder; bit 0 is the highest priority.
module irq_prio_enc
  import lcr580_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic                 valid_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: latches source edges, arbitrates unmasked requests,
// hands one vector at a time to the CPU and tracks nested in-service levels until EOI.
module irq_ctrl
  import lcr580_pkg::*;
#(
  parameter int unsigned NSRC      = 8,
  parameter logic [7:0]  PORT_BASE = IRQ_PORT_BASE,
  parameter logic [3:0]  VEC_BASE  = 4'd0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [NSRC-1:0] src,
  input  logic [7:0]      address,
  input  logic [7:0]      out,
  input  logic            port_we,
  input  logic            port_rd,
  output logic [7:0]      port_in,
  input  logic            iff1,
  output logic            irq,
  output logic [3:0]      vector
);

  localparam logic [7:0] EOI_ADDR = PORT_BASE + IRQ_EOI_OFFSET;

  irq_state_e           state_q, state_d;
  logic [NSRC-1:0]      src_q, pending_q, pending_d, mask_q, mask_d, isv_q, isv_d;
  logic                 iff1_q, irq_q, irq_d;
  logic [3:0]           vector_q, vector_d;
  logic [IRQ_IDX_W-1:0] idx_q, idx_d;

  logic [NSRC-1:0]      isv_low_c, limit_c, eligible_c;
  logic                 arb_valid_c, eoi_valid_c, ack_c, live_c, mask_wr_c, eoi_wr_c;
  logic [IRQ_IDX_W-1:0] arb_idx_c, eoi_idx_c;
  logic                 port_rd_unused;

  assign port_rd_unused = port_rd;

  // Only sources strictly above the highest-priority in-service level may nest.
  assign isv_low_c  = isv_q & (~isv_q + NSRC'(1));
  assign limit_c    = (isv_q == '0) ? '1 : (isv_low_c - NSRC'(1));
  assign eligible_c = pending_q & ~mask_q & limit_c;

  assign mask_wr_c = port_we & (address == PORT_BASE);
  assign eoi_wr_c  = port_we & (address == EOI_ADDR);
  assign ack_c     = (state_q == IRQ_REQ) & iff1_q & ~iff1;
  assign live_c    = pending_q[idx_q] & ~mask_q[idx_q];

  irq_prio_enc #(.N(NSRC)) u_arb (
    .req_i   (eligible_c),
    .valid_o (arb_valid_c),
    .idx_o   (arb_idx_c)
  );

  irq_prio_enc #(.N(NSRC)) u_eoi (
    .req_i   (isv_q),
    .valid_o (eoi_valid_c),
    .idx_o   (eoi_idx_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IRQ_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (arb_valid_c) state_d = IRQ_REQ;
      IRQ_REQ: begin
        if (ack_c)        state_d = IRQ_WAIT;
        else if (!live_c) state_d = IRQ_IDLE;
      end
      IRQ_WAIT: state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  // Next values of the registered CPU-facing outputs; vector is frozen while in REQ.
  always_comb begin
    irq_d    = irq_q;
    vector_d = vector_q;
    idx_d    = idx_q;
    case (state_q)
      IRQ_IDLE: begin
        if (arb_valid_c) begin
          irq_d    = 1'b1;
          vector_d = VEC_BASE + 4'(arb_idx_c);
          idx_d    = arb_idx_c;
        end
      end
      IRQ_REQ:  if (ack_c || !live_c) irq_d = 1'b0;
      IRQ_WAIT: irq_d = 1'b0;
      default:  irq_d = 1'b0;
    endcase
  end

  // A new edge wins over the ack clear; EOI works on the pre-ack in-service value.
  always_comb begin
    pending_d = pending_q;
    isv_d     = isv_q;
    mask_d    = mask_wr_c ? out[NSRC-1:0] : mask_q;
    if (ack_c) pending_d[idx_q] = 1'b0;
    pending_d = pending_d | (src & ~src_q);
    if (eoi_wr_c && eoi_valid_c) isv_d[eoi_idx_c] = 1'b0;
    if (ack_c) isv_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q     <= '0;
      iff1_q    <= 1'b0;
      pending_q <= '0;
      mask_q    <= '1;
      isv_q     <= '0;
      irq_q     <= 1'b0;
      vector_q  <= 4'd0;
      idx_q     <= '0;
    end else if (ce) begin
      src_q     <= src;
      iff1_q    <= iff1;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      isv_q     <= isv_d;
      irq_q     <= irq_d;
      vector_q  <= vector_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    port_in = 8'h00;
    if (address == PORT_BASE)     port_in[NSRC-1:0] = pending_q;
    else if (address == EOI_ADDR) port_in[NSRC-1:0] = isv_q;
  end

  assign irq    = irq_q;
  assign vector = vector_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand sequences for corner cases,
// and random traffic compared against a behavioural model.
module tb_irq_ctrl;

  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] F1 = 8'hF1;

  logic       clock;
  logic       reset_n, ce, port_we, port_rd, iff1, irq;
  logic [7:0] src, address, wdata, port_in;
  logic [3:0] vector;

  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl #(.NSRC(8), .PORT_BASE(8'hF0), .VEC_BASE(4'd0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .src     (src),
    .address (address),
    .out     (wdata),
    .port_we (port_we),
    .port_rd (port_rd),
    .port_in (port_in),
    .iff1    (iff1),
    .irq     (irq),
    .vector  (vector)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state
  logic [7:0] m_pending, m_mask, m_isv, m_src_q;
  logic       m_iff1_q, m_irq, m_busy, m_settle;
  logic [3:0] m_vec;
  int         m_idx;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_reset();
    m_pending = 8'h00; m_mask = 8'hFF; m_isv = 8'h00; m_src_q = 8'h00;
    m_iff1_q = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_settle = 1'b0;
    m_vec = 4'h0; m_idx = 0;
  endtask

  // Apply one clock of the interrupt rules to the model, using the inputs now on the pins.
  task automatic model_step();
    logic       acked, live;
    int         lim, win;
    logic [7:0] np, ni;
    if (!ce) return;
    acked = m_busy && m_iff1_q && !iff1;
    live  = m_pending[m_idx] && !m_mask[m_idx];
    lim   = lowest(m_isv);
    win   = -1;
    for (int i = lim - 1; i >= 0; i--)
      if (m_pending[i] && !m_mask[i]) win = i;
    np = m_pending;
    ni = m_isv;
    if (acked) np[m_idx] = 1'b0;
    np = np | (src & ~m_src_q);
    if (port_we && address == F1 && lim < 8) ni[lim] = 1'b0;
    if (acked) ni[m_idx] = 1'b1;
    if (m_settle) begin
      m_settle = 1'b0;
    end else if (m_busy) begin
      if (acked) begin
        m_busy = 1'b0; m_settle = 1'b1; m_irq = 1'b0;
      end else if (!live) begin
        m_busy = 1'b0; m_irq = 1'b0;
      end
    end else if (win >= 0) begin
      m_busy = 1'b1; m_idx = win; m_irq = 1'b1; m_vec = 4'(win);
    end
    if (port_we && address == F0) m_mask = wdata;
    m_pending = np;
    m_isv     = ni;
    m_src_q   = src;
    m_iff1_q  = iff1;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    if (a == F0) return m_pending;
    if (a == F1) return m_isv;
    return 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
    address = a;
    #1;
    chk(nm, port_in, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ce = 1'b1; src = 8'h00; port_we = 1'b0; port_rd = 1'b0;
    iff1 = 1'b1; address = F0; wdata = 8'h00;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; wdata = d; port_we = 1'b1;
    step();
    port_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] s);
    src = s;
    step();
    src = 8'h00;
    step();
  endtask

  task automatic ack();
    iff1 = 1'b0;
    step();
    iff1 = 1'b1;
    step();
  endtask

  task automatic init();
    do_reset();
    wr(F0, 8'h00);
  endtask

  typedef struct {
    logic       ce;
    logic [7:0] src;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wd;
    logic       iff1;
    logic       exp_irq;
    logic [3:0] exp_vec;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tv[9];

  initial begin
    // Single request on src[3], acked two cycles after irq, then EOI.
    tv[0] = '{1'b1, 8'h00, F0,    1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00};
    tv[1] = '{1'b1, 8'h08, F0,    1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h08};
    tv[2] = '{1'b1, 8'h00, F0,    1'b0, 8'h00, 1'b1, 1'b1, 4'h3, 8'h08};
    tv[3] = '{1'b1, 8'h00, F0,    1'b0, 8'h00, 1'b1, 1'b1, 4'h3, 8'h08};
    tv[4] = '{1'b1, 8'h00, F1,    1'b0, 8'h00, 1'b0, 1'b0, 4'h3, 8'h08};
    tv[5] = '{1'b1, 8'h00, F0,    1'b0, 8'h00, 1'b0, 1'b0, 4'h3, 8'h00};
    tv[6] = '{1'b1, 8'h00, F1,    1'b0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h08};
    tv[7] = '{1'b1, 8'h00, F1,    1'b1, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00};
    tv[8] = '{1'b1, 8'h00, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00};

    do_reset();
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_vec", 8'(vector), 8'h00);
    chk_rd("rst_pend", F0, 8'h00);
    chk_rd("rst_isv", F1, 8'h00);

    for (int i = 0; i < 9; i++) begin
      ce = tv[i].ce; src = tv[i].src; address = tv[i].addr;
      port_we = tv[i].we; wdata = tv[i].wd; iff1 = tv[i].iff1;
      step();
      chk($sformatf("tbl%0d_irq", i), 8'(irq), 8'(tv[i].exp_irq));
      chk($sformatf("tbl%0d_vec", i), 8'(vector), 8'(tv[i].exp_vec));
      chk($sformatf("tbl%0d_rd", i), port_in, tv[i].exp_rd);
    end
    port_we = 1'b0;

    // Two simultaneous requests: 2 first, 5 only after EOI.
    init();
    pulse(8'h24);
    chk("s2_irq", 8'(irq), 8'h01);
    chk("s2_vec", 8'(vector), 8'h02);
    chk_rd("s2_pend", F0, 8'h24);
    ack();
    step();
    chk("s2_blocked", 8'(irq), 8'h00);
    chk_rd("s2_pend5", F0, 8'h20);
    wr(F1, 8'h00);
    step();
    chk("s2_irq5", 8'(irq), 8'h01);
    chk("s2_vec5", 8'(vector), 8'h05);
    chk_rd("s2_pend5b", F0, 8'h20);
    ack();
    chk_rd("s2_isv", F1, 8'h20);

    // Nesting below and above an in-service level.
    init();
    pulse(8'h10);
    ack();
    chk_rd("s3_isv4", F1, 8'h10);
    pulse(8'h40);
    step();
    chk("s3_low_blocked", 8'(irq), 8'h00);
    pulse(8'h02);
    chk("s3_nest_irq", 8'(irq), 8'h01);
    chk("s3_nest_vec", 8'(vector), 8'h01);
    ack();
    chk_rd("s3_isv12", F1, 8'h12);
    wr(F1, 8'h00);
    chk_rd("s3_isv10", F1, 8'h10);
    wr(F1, 8'h00);
    chk_rd("s3_isv0", F1, 8'h00);

    // Mask write while in REQ withdraws the request.
    init();
    pulse(8'h10);
    chk("s4_irq", 8'(irq), 8'h01);
    wr(F0, 8'h10);
    chk("s4_irq_hold", 8'(irq), 8'h01);
    step();
    chk("s4_withdrawn", 8'(irq), 8'h00);
    chk_rd("s4_pend", F0, 8'h10);
    wr(F0, 8'h00);
    step();
    chk("s4_reirq", 8'(irq), 8'h01);
    chk("s4_revec", 8'(vector), 8'h04);

    // Clock enable low freezes everything, including the edge and iff1 samplers.
    init();
    pulse(8'h01);
    chk("s5_irq", 8'(irq), 8'h01);
    ce = 1'b0; src = 8'h04; iff1 = 1'b0;
    step();
    step();
    chk("s5_hold_irq", 8'(irq), 8'h01);
    chk("s5_hold_vec", 8'(vector), 8'h00);
    chk_rd("s5_hold_pend", F0, 8'h01);
    ce = 1'b1;
    step();
    chk("s5_ack", 8'(irq), 8'h00);
    chk_rd("s5_pend", F0, 8'h04);
    chk_rd("s5_isv", F1, 8'h01);
    src = 8'h00; iff1 = 1'b1;
    step();

    // Asynchronous reset while irq is high.
    init();
    pulse(8'h08);
    chk("s6_irq", 8'(irq), 8'h01);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("s6_rst_irq", 8'(irq), 8'h00);
    chk("s6_rst_vec", 8'(vector), 8'h00);
    chk_rd("s6_rst_pend", F0, 8'h00);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pulse(8'h08);
    step();
    chk("s6_masked", 8'(irq), 8'h00);
    chk_rd("s6_pend", F0, 8'h08);
    wr(F0, 8'h00);
    step();
    chk("s6_irq_after", 8'(irq), 8'h01);
    chk("s6_vec_after", 8'(vector), 8'h03);

    // Random traffic against the model.
    init();
    for (int n = 0; n < 3000; n++) begin
      ce  = ($urandom_range(0, 9) != 0);
      src = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      case ($urandom_range(0, 2))
        0:       address = F0;
        1:       address = F1;
        default: address = 8'($urandom);
      endcase
      port_we = ($urandom_range(0, 7) == 0);
      wdata   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      port_rd = 1'($urandom);
      if ($urandom_range(0, 3) == 0) iff1 = ~iff1;
      step();
      chk("rnd_irq", 8'(irq), 8'(m_irq));
      chk("rnd_vec", 8'(vector), 8'(m_vec));
      chk("rnd_rd", port_in, model_rd(address));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
